// File: rtl/bcm_slot_sequencer_if.sv
// Bus between the brightness source and the BCM slot sequencer.
// The master drives the time base, run request and brightness words; the slave returns the pin outputs and status.
interface bcm_slot_sequencer_if #(
    parameter int NUM_CH    = 6,
    parameter int NUM_SLOTS = 4
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                        TICK;
    logic                        EN;
    logic [NUM_CH*NUM_SLOTS-1:0] DATA;
    logic [NUM_CH-1:0]           Q;
    logic [SLOT_W-1:0]           SLOT;
    logic                        FRAME_START;
    logic                        BUSY;

    modport master (output TICK, EN, DATA, input Q, SLOT, FRAME_START, BUSY);
    modport slave  (input TICK, EN, DATA, output Q, SLOT, FRAME_START, BUSY);
endinterface

// File: rtl/bcm_slot_sequencer.sv
// Binary-code-modulation sequencer: binary-weighted slots, each followed by a forced-low guard.
// Define BCM_ACTIVE_LOW_EN to invert Q at the output register for active-low LED pins.
//
// state  | meaning
// IDLE   | outputs parked, waiting for EN
// ACTIVE | slot SLOT running, Q follows latched bit SLOT of each channel
// GUARD  | forced-off gap after a slot, SLOT holds
module bcm_slot_sequencer #(
    parameter int NUM_CH    = 6,
    parameter int NUM_SLOTS = 4,
    parameter int BASE_LEN  = 100,
    parameter int GUARD_LEN = 4,
    parameter int CNT_W     = 11
) (
    input  logic                CLK,
    input  logic                RST,
    bcm_slot_sequencer_if.slave bus
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0]  GUARD_LOAD = CNT_W'((GUARD_LEN > 0) ? GUARD_LEN - 1 : 0);
`ifdef BCM_ACTIVE_LOW_EN
    localparam logic Q_INV = 1'b1;
`else
    localparam logic Q_INV = 1'b0;
`endif
    localparam logic [NUM_CH-1:0] Q_OFF = {NUM_CH{Q_INV}};

    typedef enum logic [1:0] {IDLE, ACTIVE, GUARD} state_t;

    state_t                      state_r, state_n;
    logic [CNT_W-1:0]            cnt_r, cnt_n;
    logic [SLOT_W-1:0]           slot_r, slot_n;
    logic [NUM_CH*NUM_SLOTS-1:0] data_r, data_n;
    logic [NUM_CH-1:0]           q_r, q_n;
    logic                        fs_r, fs_n;
    logic                        busy_r;
    logic                        adv;
    logic [NUM_SLOTS-1:0]        word;

    function automatic logic [CNT_W-1:0] slot_len_m1(input logic [SLOT_W-1:0] s);
        return (CNT_W'(BASE_LEN) << s) - CNT_W'(1);
    endfunction

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        slot_n  = slot_r;
        data_n  = data_r;
        fs_n    = 1'b0;
        adv     = 1'b0;
        word    = '0;
        q_n     = Q_OFF;

        unique case (state_r)
            IDLE: begin
                if (bus.EN) begin
                    state_n = ACTIVE;
                    slot_n  = '0;
                    data_n  = bus.DATA;
                    fs_n    = 1'b1;
                    cnt_n   = slot_len_m1('0);
                end
            end
            ACTIVE: begin
                if (bus.TICK) begin
                    if (cnt_r == '0) begin
                        if (GUARD_LEN > 0) begin
                            state_n = GUARD;
                            cnt_n   = GUARD_LOAD;
                        end else begin
                            adv = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_r - CNT_W'(1);
                    end
                end
            end
            GUARD: begin
                if (bus.TICK) begin
                    if (cnt_r == '0) adv = 1'b1;
                    else             cnt_n = cnt_r - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Slot advance; the frame boundary re-latches DATA only while EN is still requested
        if (adv) begin
            if (slot_r != LAST_SLOT) begin
                state_n = ACTIVE;
                slot_n  = slot_r + SLOT_W'(1);
                cnt_n   = slot_len_m1(slot_r + SLOT_W'(1));
            end else if (bus.EN) begin
                state_n = ACTIVE;
                slot_n  = '0;
                data_n  = bus.DATA;
                fs_n    = 1'b1;
                cnt_n   = slot_len_m1('0);
            end else begin
                state_n = IDLE;
                slot_n  = '0;
                cnt_n   = '0;
            end
        end

        if (state_n == ACTIVE) begin
            for (int c = 0; c < NUM_CH; c++) begin
                word   = data_n[c*NUM_SLOTS +: NUM_SLOTS];
                q_n[c] = word[slot_n] ^ Q_INV;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            slot_r  <= '0;
            data_r  <= '0;
            q_r     <= Q_OFF;
            fs_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            slot_r  <= slot_n;
            data_r  <= data_n;
            q_r     <= q_n;
            fs_r    <= fs_n;
            busy_r  <= (state_n != IDLE);
        end
    end

    assign bus.Q           = q_r;
    assign bus.SLOT        = slot_r;
    assign bus.FRAME_START = fs_r;
    assign bus.BUSY        = busy_r;
endmodule

// File: doc/bcm_slot_sequencer.md
Name: bcm_slot_sequencer

Overview:
- Multi-channel binary-code-modulation (BCM) output sequencer for LED dimming.
- Steps through NUM_SLOTS binary-weighted time slots; slot k lasts BASE_LEN<<k ticks.
- A guard interval with all outputs low follows each slot.
- Each channel's output is high during slot k when bit k of that channel's latched brightness word is 1.
- Fully synchronous and parametrised in channels, slots, base length and guard length.
- Sits between the brightness registers and the LED pins.

Parameters:
- NUM_CH, 6, number of output channels.
- NUM_SLOTS, 4, bits per brightness word, which is also the number of slots per frame.
- BASE_LEN, 100, length of slot 0 in ticks; must be 1 or more.
- GUARD_LEN, 4, ticks of forced-low guard after each slot; 0 means no guard state.
- CNT_W, 11, duration counter width; must satisfy 2^CNT_W > BASE_LEN<<(NUM_SLOTS-1).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- TICK  in  1  time-base enable; durations count TICK-qualified cycles.
- EN  in  1  run request.
- DATA  in  NUM_CH*NUM_SLOTS  brightness words; channel c occupies bits [c*NUM_SLOTS +: NUM_SLOTS].
- Q  out  NUM_CH  modulated channel outputs, registered.
- SLOT  out  $clog2(NUM_SLOTS) (minimum 1)  index of the current slot, registered.
- FRAME_START  out  1  one-CLK pulse when a frame begins and DATA is latched.
- BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (RST sampled high):
  - state = IDLE; Q = 0, SLOT = 0, FRAME_START = 0, BUSY = 0.
  - Duration counter = 0; latched data = 0.
  - RST takes priority over every other input and aborts any frame in progress.
- States: IDLE, ACTIVE, GUARD.
- IDLE:
  - Q = 0, SLOT = 0.
  - On an edge where EN = 1: latch DATA, pulse FRAME_START, enter ACTIVE with SLOT = 0. This transition does not depend on TICK.
- ACTIVE:
  - Q[c] = latched bit (c*NUM_SLOTS + SLOT).
  - The counter is loaded with (BASE_LEN<<SLOT)-1 on entry and decrements on each TICK.
  - The state exits on the TICK edge where the counter is 0, so the slot lasts exactly BASE_LEN<<SLOT ticks.
  - Exit goes to GUARD if GUARD_LEN > 0; otherwise it goes straight to the next-slot step.
- GUARD:
  - Q = 0 and SLOT holds.
  - Lasts exactly GUARD_LEN ticks, using the same load/decrement rule, then goes to the next-slot step.
- Next-slot step:
  - If SLOT < NUM_SLOTS-1: SLOT increments and the state enters ACTIVE.
  - If SLOT = NUM_SLOTS-1 (frame boundary) and EN = 1: SLOT wraps to 0, DATA is re-latched, FRAME_START pulses and the state enters ACTIVE.
  - If SLOT = NUM_SLOTS-1 and EN = 0: enter IDLE.
- Q, SLOT, BUSY and FRAME_START change on the same CLK edge as the state transition. No combinational path runs from any input to any output.
- DATA is sampled only at frame start; changes mid-frame take effect at the next frame.
- EN dropping mid-frame has no effect until the frame boundary, so the frame always completes.
- TICK = 0 freezes the counter, state and outputs, except for the IDLE-to-ACTIVE start.
- Frame length in ticks = BASE_LEN*(2^NUM_SLOTS - 1) + NUM_SLOTS*GUARD_LEN.
- Per-channel on-time in ticks = BASE_LEN * brightness word.

Optional Feature:
- Macro BCM_ACTIVE_LOW_EN.
- When defined:
  - Q is inverted at the output register, for directly driving active-low LED pins.
  - Reset/IDLE/GUARD value of Q is all ones; ACTIVE drives the inverted latched bit.
  - All other outputs are unchanged.
- When undefined: Q is active-high as described above.

Test Plan:
All scenarios use NUM_CH=2, NUM_SLOTS=4, BASE_LEN=2, GUARD_LEN=1, TICK tied high (frame = 34 cycles) unless stated.
1. RST high for 3 cycles, then EN=1 with DATA={4'h5,4'hA} -> FRAME_START pulses once every 34 cycles.
   - Q[0] (0xA) high for 4 consecutive cycles (slot 1) and 16 consecutive cycles (slot 3).
   - Q[1] (0x5) high for 2 (slot 0) and 8 (slot 2).
   - Q=0 for the single guard cycle after each slot.
2. DATA changed mid-frame from 0xF to 0x0 -> the current frame still outputs all slots high; the next frame keeps Q=0 for its full 34 cycles.
3. EN dropped during slot 1 -> the frame completes through slot 3 and its guard, then IDLE with BUSY=0; EN raised later -> FRAME_START on the next edge.
4. TICK as one pulse every 3 cycles -> slot 2 ACTIVE lasts 8 ticks = 24 CLK cycles; all outputs frozen between ticks.
5. RST asserted during slot 2 -> next cycle Q=0, SLOT=0, BUSY=0; restart latches fresh DATA.
6. GUARD_LEN=0 build -> frame = 30 cycles; with DATA 0xF, Q stays high continuously across slot boundaries with no low gap.
